// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Optional same-cycle read bypass is enabled with REGFILE_BYPASS_EN.
package regfile_sb_pkg;

   localparam int DATAWIDTH_DEF = 16;
   localparam int REGWIDTH_DEF  = 4;
   localparam int LDQ_DEPTH_DEF = 2;

   // Occupancy must represent both 0 and DEPTH.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/regfile_sb_ldq.sv
// Pending-load tag FIFO; the owner guarantees no push when full
// without a same-cycle pop, and no pop when empty.
module regfile_ldq
   import regfile_sb_pkg::*;
#(
   parameter int TAGW  = REGWIDTH_DEF,
   parameter int DEPTH = LDQ_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push_i,
   input  logic [TAGW-1:0] tag_i,
   input  logic            pop_i,
   output logic [TAGW-1:0] head_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [TAGW-1:0] tags_q [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   assign head_o  = tags_q[rptr_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

   // Power-of-two depth lets the pointers wrap by overflow.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (push_i) tags_q[wptr_q] <= tag_i;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with load scoreboard and pending-load tag queue.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int REGWIDTH  = REGWIDTH_DEF,
   parameter int LDQ_DEPTH = LDQ_DEPTH_DEF,
   parameter int PC_ALIAS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REGWIDTH-1:0]  rSrc,
   input  logic [REGWIDTH-1:0]  rDst,
   output logic [DATAWIDTH-1:0] dSrc,
   output logic [DATAWIDTH-1:0] dDst,
   output logic                 src_busy,
   output logic                 dst_busy,
   input  logic [DATAWIDTH-1:0] pc,
   input  logic                 write,
   input  logic [REGWIDTH-1:0]  wr_addr,
   input  logic [DATAWIDTH-1:0] write_data,
   input  logic                 ld_issue,
   input  logic [REGWIDTH-1:0]  ld_addr,
   output logic                 ld_ready,
   input  logic                 ld_valid,
   input  logic [DATAWIDTH-1:0] ld_data,
   output logic                 ld_err
);

   localparam int NREG = 2 ** REGWIDTH;
   localparam logic [REGWIDTH-1:0] TOP = '1;

   logic [DATAWIDTH-1:0] regs_q [NREG];
   logic [NREG-1:0]      busy_q, busy_d;
   logic                 ld_err_q;

   logic                 push, pop, full, empty;
   logic [REGWIDTH-1:0]  head;
   logic [REGWIDTH-1:0]  raddr [2];
   logic [DATAWIDTH-1:0] rdata [2];
   logic                 rbusy [2];

   // A full queue may still accept when the head retires this cycle.
   assign ld_ready = !full || ld_valid;
   assign push     = ld_issue && ld_ready && !reset;
   assign pop      = ld_valid && !empty && !reset;
   assign ld_err   = ld_err_q;

   regfile_ldq #(
      .TAGW  (REGWIDTH),
      .DEPTH (LDQ_DEPTH)
   ) u_ldq (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .tag_i   (ld_addr),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // Set after clear so a re-issued tag stays busy.
   always_comb begin
      busy_d = busy_q;
      if (pop)  busy_d[head]    = 1'b0;
      if (push) busy_d[ld_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         busy_q   <= '0;
         ld_err_q <= 1'b0;
      end else begin
         if (pop)   regs_q[head]    <= ld_data;
         if (write) regs_q[wr_addr] <= write_data;
         busy_q   <= busy_d;
         ld_err_q <= ld_valid && empty;
      end
   end

   assign raddr[0] = rSrc;
   assign raddr[1] = rDst;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = regs_q[raddr[p]];
         rbusy[p] = busy_q[raddr[p]];
`ifdef REGFILE_BYPASS_EN
         if (pop && raddr[p] == head) begin
            rdata[p] = ld_data;
            rbusy[p] = 1'b0;
         end
         if (write && raddr[p] == wr_addr) rdata[p] = write_data;
`endif
         if (PC_ALIAS == 1 && raddr[p] == TOP) begin
            rdata[p] = pc;
            rbusy[p] = 1'b0;
         end
      end
   end

   assign dSrc     = rdata[0];
   assign dDst     = rdata[1];
   assign src_busy = rbusy[0];
   assign dst_busy = rbusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed cycles queue expectations,
// a negedge monitor pops and compares them.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  rSrc, rDst, wr_addr, ld_addr;
   logic [15:0] dSrc, dDst, pc, write_data, ld_data;
   logic        src_busy, dst_busy, write, ld_issue, ld_ready;
   logic        ld_valid, ld_err;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk        (clk),
      .reset      (reset),
      .rSrc       (rSrc),
      .rDst       (rDst),
      .dSrc       (dSrc),
      .dDst       (dDst),
      .src_busy   (src_busy),
      .dst_busy   (dst_busy),
      .pc         (pc),
      .write      (write),
      .wr_addr    (wr_addr),
      .write_data (write_data),
      .ld_issue   (ld_issue),
      .ld_addr    (ld_addr),
      .ld_ready   (ld_ready),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_err     (ld_err)
   );

   typedef struct {
      string       name;
      logic [15:0] ds;
      logic        sb;
      logic [15:0] dd;
      logic        db;
      logic        rdy;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   popped = 0;
   logic chk = 1'b0;

`ifdef REGFILE_BYPASS_EN
   localparam logic [15:0] BYP_R1 = 16'hBEEF;
`else
   localparam logic [15:0] BYP_R1 = 16'h0000;
`endif

   task automatic cmp16(input string n, input string f,
                        input logic [15:0] act, input logic [15:0] exv);
      checks++;
      if (act !== exv) begin
         errors++;
         $display("FAIL %s.%s: got %h want %h", n, f, act, exv);
      end
   endtask

   task automatic cmp1(input string n, input string f,
                       input logic act, input logic exv);
      checks++;
      if (act !== exv) begin
         errors++;
         $display("FAIL %s.%s: got %b want %b", n, f, act, exv);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL monitor: got empty queue want entry");
         end else begin
            e = sb_q.pop_front();
            popped++;
            cmp16(e.name, "dSrc", dSrc, e.ds);
            cmp1(e.name, "src_busy", src_busy, e.sb);
            cmp16(e.name, "dDst", dDst, e.dd);
            cmp1(e.name, "dst_busy", dst_busy, e.db);
            cmp1(e.name, "ld_ready", ld_ready, e.rdy);
            cmp1(e.name, "ld_err", ld_err, e.err);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      reset    = 1'b0;
      write    = 1'b0;
      ld_issue = 1'b0;
      ld_valid = 1'b0;
      chk      = 1'b0;
   endtask

   task automatic exp_chk(input string n, input logic [3:0] s,
                          input logic [3:0] d, input logic [15:0] ds,
                          input logic sbz, input logic [15:0] dd,
                          input logic db, input logic rdy,
                          input logic err);
      rSrc = s;
      rDst = d;
      sb_q.push_back('{name: n, ds: ds, sb: sbz, dd: dd, db: db,
                       rdy: rdy, err: err});
      pushed++;
      chk = 1'b1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      write      = 1'b1;
      wr_addr    = a;
      write_data = d;
   endtask

   task automatic iss(input logic [3:0] a);
      ld_issue = 1'b1;
      ld_addr  = a;
   endtask

   task automatic ret(input logic [15:0] d);
      ld_valid = 1'b1;
      ld_data  = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; write = 1'b0; ld_issue = 1'b0; ld_valid = 1'b0;
      rSrc = '0; rDst = '0; wr_addr = '0; ld_addr = '0;
      write_data = '0; ld_data = '0; pc = 16'h00F0;
      @(posedge clk); #1;
      cyc();
      wr(3, 16'h1234);
      exp_chk("reset", 0, 15, 16'h0, 0, 16'h00F0, 0, 1, 0); cyc();
      iss(5);
      exp_chk("wr_r3", 3, 0, 16'h1234, 0, 16'h0, 0, 1, 0); cyc();
      iss(6);
      exp_chk("busy5", 5, 6, 16'h0, 1, 16'h0, 0, 1, 0); cyc();
      iss(7);
      exp_chk("full", 5, 6, 16'h0, 1, 16'h0, 1, 0, 0); cyc();
      ret(16'hAAAA);
      exp_chk("r7_idle", 7, 6, 16'h0, 0, 16'h0, 1, 1, 0); cyc();
      ret(16'hBBBB);
      exp_chk("r5_ld", 5, 7, 16'hAAAA, 0, 16'h0, 0, 1, 0); cyc();
      iss(8);
      exp_chk("r6_ld", 6, 7, 16'hBBBB, 0, 16'h0, 0, 1, 0); cyc();
      iss(9);
      exp_chk("busy8", 8, 9, 16'h0, 1, 16'h0, 0, 1, 0); cyc();
      iss(2); ret(16'h0F0F);
      exp_chk("full_pp", 9, 2, 16'h0, 1, 16'h0, 0, 1, 0); cyc();
      exp_chk("pp_occ", 8, 2, 16'h0F0F, 0, 16'h0, 1, 0, 0); cyc();
      ret(16'h0909);
      exp_chk("pop9", 4, 0, 16'h0, 0, 16'h0, 0, 1, 0); cyc();
      ret(16'h0202); iss(4);
      exp_chk("r9", 9, 0, 16'h0909, 0, 16'h0, 0, 1, 0); cyc();
      exp_chk("r2_busy4", 2, 4, 16'h0202, 0, 16'h0, 1, 1, 0); cyc();
      wr(4, 16'h1111); ret(16'h2222);
      exp_chk("wb_same", 2, 3, 16'h0202, 0, 16'h1234, 0, 1, 0); cyc();
      iss(9);
      exp_chk("r4_alu", 4, 0, 16'h1111, 0, 16'h0, 0, 1, 0); cyc();
      reset = 1'b1;
      exp_chk("busy9", 9, 0, 16'h0909, 1, 16'h0, 0, 1, 0); cyc();
      ret(16'h5555);
      exp_chk("post_rst", 9, 4, 16'h0, 0, 16'h0, 0, 1, 0); cyc();
      exp_chk("err_pulse", 9, 15, 16'h0, 0, 16'h00F0, 0, 1, 1); cyc();
      wr(15, 16'h7777);
      exp_chk("err_once", 15, 9, 16'h00F0, 0, 16'h0, 0, 1, 0); cyc();
      exp_chk("alias", 15, 1, 16'h00F0, 0, 16'h0, 0, 1, 0); cyc();
      wr(1, 16'hBEEF);
      exp_chk("bypass", 1, 0, BYP_R1, 0, 16'h0, 0, 1, 0); cyc();
      exp_chk("r1", 1, 15, 16'hBEEF, 0, 16'h00F0, 0, 1, 0); cyc();
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb_q.size() != 0 || pushed != popped) begin
         errors++;
         $display("FAIL drain: got %0d popped want %0d", popped, pushed);
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
